// File: rtl/mod12_sync_loadable_downcounter_pkg.sv
// Definitions shared by the mod-N loadable counters: FSM state encodings and the
// default counter geometry.
package mod12_sync_loadable_downcounter_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } cnt_state_t;

endpackage

// File: rtl/mod12_sync_loadable_downcounter_mod_n_dec.sv
// Modulo-N decrement step: the next count value and an underflow flag.
module mod_n_dec
    import mod12_sync_loadable_downcounter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             wrap,
    output logic [WIDTH-1:0] nxt,
    output logic             uf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    always_comb begin
        uf  = (cur == '0);
        nxt = cur - WIDTH'(1);
        // Without wrap the count parks at 0 so it never leaves the legal range.
        if (uf) begin
            nxt = wrap ? MAX_VAL : '0;
        end
    end

endmodule

// File: rtl/mod12_sync_loadable_downcounter.sv
// Loadable modulo-N down counter / reload timer with borrow output and load validation.
//
// state    | meaning
// ST_IDLE  | after reset, holds at 0 until the first load
// ST_COUNT | decrementing while en is high
// ST_DONE  | one-shot expired, holds at 0 until the next load
module mod12_sync_loadable_downcounter
    import mod12_sync_loadable_downcounter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] dout,
    output logic             borrow,
    output logic             zero,
    output logic             load_err,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One bit wider so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             borrow_q, borrow_d;
    logic             load_err_q, load_err_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] dec_nxt;
    logic             dec_uf;

    mod_n_dec #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_dec (
        .cur  (dout_q),
        .wrap (auto_reload),
        .nxt  (dec_nxt),
        .uf   (dec_uf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dout_q     <= '0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            state_d = ST_COUNT;
            if ({1'b0, din} >= MOD_EXT) begin
                dout_d     = MAX_VAL;
                load_err_d = 1'b1;
            end else begin
                dout_d = din;
            end
        end else if (state_q == ST_COUNT && en) begin
            dout_d   = dec_nxt;
            borrow_d = dec_uf;
            if (dec_uf && !auto_reload) begin
                state_d = ST_DONE;
            end
        end
        busy_d = (state_d == ST_COUNT);
    end

    always_comb begin
        dout     = dout_q;
        borrow   = borrow_q;
        load_err = load_err_q;
        busy     = busy_q;
        zero     = (dout_q == '0);
    end

endmodule

// File: tb/tb_mod12_sync_loadable_downcounter.sv
// Directed bench for the mod-12 loadable down counter, checked every cycle against a
// behavioural model plus hand-computed expectations.
module tb_mod12_sync_loadable_downcounter;

    localparam int W = 4;
    localparam int N = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] din;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] dout;
    logic         borrow;
    logic         zero;
    logic         load_err;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    mod12_sync_loadable_downcounter #(.WIDTH(W), .MODULUS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .din         (din),
        .en          (en),
        .auto_reload (auto_reload),
        .dout        (dout),
        .borrow      (borrow),
        .zero        (zero),
        .load_err    (load_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 counting, 2 expired.
    int m_cnt    = 0;
    int m_mode   = 0;
    int m_borrow = 0;
    int m_err    = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_mode = 0; m_borrow = 0; m_err = 0;
        end else begin
            m_borrow = 0;
            m_err    = 0;
            if (load) begin
                m_mode = 1;
                if (int'(din) >= N) begin
                    m_cnt = N - 1;
                    m_err = 1;
                end else begin
                    m_cnt = int'(din);
                end
            end else if (m_mode == 1 && en) begin
                if (m_cnt == 0) begin
                    m_borrow = 1;
                    if (auto_reload) m_cnt = N - 1;
                    else             m_mode = 2;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_dout",     int'(dout),     m_cnt);
        chk("model_borrow",   int'(borrow),   m_borrow);
        chk("model_load_err", int'(load_err), m_err);
        chk("model_busy",     int'(busy),     (m_mode == 1) ? 1 : 0);
        chk("model_zero",     int'(zero),     (m_cnt == 0) ? 1 : 0);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int t;
        int first;
        int second;

        rst = 1'b0; load = 1'b1; en = 1'b1; din = 4'd5; auto_reload = 1'b0;
        cyc(2);
        chk("rst_dout", int'(dout), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_borrow", int'(borrow), 0);
        rst = 1'b1; load = 1'b0;
        cyc(3);
        chk("idle_dout", int'(dout), 0);
        chk("idle_busy", int'(busy), 0);

        // one-shot from 3
        load = 1'b1; din = 4'd3; auto_reload = 1'b0; en = 1'b1;
        cyc(1);
        chk("os_load", int'(dout), 3);
        chk("os_busy", int'(busy), 1);
        load = 1'b0;
        cyc(1); chk("os_2", int'(dout), 2);
        cyc(1); chk("os_1", int'(dout), 1);
        cyc(1); chk("os_0", int'(dout), 0);
        chk("os_no_borrow_yet", int'(borrow), 0);
        cyc(1);
        chk("os_borrow", int'(borrow), 1);
        chk("os_done_busy", int'(busy), 0);
        cyc(5);
        chk("os_hold_dout", int'(dout), 0);
        chk("os_hold_borrow", int'(borrow), 0);

        // auto-reload from 2: borrows at 3 and 15 cycles after the load edge
        load = 1'b1; din = 4'd2; auto_reload = 1'b1;
        cyc(1);
        chk("ar_load", int'(dout), 2);
        load = 1'b0;
        t = 0; first = -1; second = -1;
        for (int i = 0; i < 40 && second < 0; i++) begin
            cyc(1);
            t++;
            if (borrow) begin
                if (first < 0) begin
                    first = t;
                    chk("ar_wrap_dout", int'(dout), 11);
                end else begin
                    second = t;
                end
            end
        end
        chk("ar_first_borrow", first, 3);
        chk("ar_period", second - first, 12);

        // invalid loads saturate
        load = 1'b1; din = 4'd14; auto_reload = 1'b0;
        cyc(1);
        chk("bad14_dout", int'(dout), 11);
        chk("bad14_err", int'(load_err), 1);
        load = 1'b0;
        cyc(1);
        chk("bad14_err_clr", int'(load_err), 0);
        chk("bad14_10", int'(dout), 10);
        cyc(1); chk("bad14_9", int'(dout), 9);
        load = 1'b1; din = 4'd12;
        cyc(1);
        chk("bad12_err", int'(load_err), 1);
        chk("bad12_dout", int'(dout), 11);
        din = 4'd11;
        cyc(1);
        chk("ok11_err", int'(load_err), 0);
        chk("ok11_dout", int'(dout), 11);

        // load beats en; en=0 holds
        din = 4'd5; en = 1'b1;
        cyc(1);
        chk("ld_pri_dout", int'(dout), 5);
        chk("ld_pri_borrow", int'(borrow), 0);
        load = 1'b0;
        cyc(1); chk("en_4", int'(dout), 4);
        en = 1'b0;
        cyc(3); chk("en_hold", int'(dout), 4);
        en = 1'b1;
        cyc(1); chk("en_3", int'(dout), 3);

        // load 0 underflows on the next enabled edge
        load = 1'b1; din = 4'd0;
        cyc(1);
        chk("z_dout", int'(dout), 0);
        chk("z_busy", int'(busy), 1);
        load = 1'b0;
        cyc(1);
        chk("z_borrow", int'(borrow), 1);
        chk("z_done", int'(busy), 0);

        // async reset mid-count at dout=7
        load = 1'b1; din = 4'd9;
        cyc(1);
        load = 1'b0;
        cyc(2);
        chk("ar7_dout", int'(dout), 7);
        #1 rst = 1'b0;
        #1;
        chk("async_dout", int'(dout), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_zero", int'(zero), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        cyc(3);
        chk("post_rst_dout", int'(dout), 0);
        chk("post_rst_busy", int'(busy), 0);
        load = 1'b1; din = 4'd4;
        cyc(1);
        chk("post_rst_load", int'(dout), 4);
        load = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
